// File: rtl/sw_event_scheduler_if.sv
// Event port of the switch scheduler: one valid/ready channel carrying the
// index of the switch that changed and the direction of the change.
interface sw_event_scheduler_if #(
    parameter int ID_W = 2
) ();
    logic            evt_valid_o;
    logic            evt_ready_i;
    logic [ID_W-1:0] evt_id_o;
    logic            evt_rise_o;

    modport master (
        output evt_valid_o,
        output evt_id_o,
        output evt_rise_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_id_o,
        input  evt_rise_o,
        output evt_ready_i
    );
endinterface

// File: rtl/sw_event_scheduler.sv
// Debounces N_SW switches on one shared sample tick and delivers every accepted
// level change as a press/release event, round-robin, on a single valid/ready port.
module sw_event_scheduler #(
    parameter int N_SW       = 4,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 8
) (
    input  logic                 clk_50,
    input  logic                 reset_n,
    input  logic [N_SW-1:0]      sw_i,
    output logic [N_SW-1:0]      sw_state_o,
    output logic                 ovf_o,
    input  logic                 ovf_clr_i,
    sw_event_scheduler_if.master evt
);
    // The connected interface must be instantiated with ID_W matching this value.
    localparam int ID_W  = (N_SW > 1) ? $clog2(N_SW) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    typedef enum logic {S_IDLE, S_PRESENT} state_t;

    logic [N_SW-1:0]  sync1_reg;
    logic [N_SW-1:0]  sync2_reg;
    logic [PRE_W-1:0] pre_reg;
    logic             tick;
    logic [N_SW-1:0]  pend_vec;
    logic [N_SW-1:0]  rise_vec;
    logic [N_SW-1:0]  ovf_set_vec;
    logic [N_SW-1:0]  capture_vec;
    logic             ovf_reg;

    state_t           fsm_reg, fsm_next;
    logic             valid_reg, valid_next;
    logic             rise_out_reg, rise_out_next;
    logic [ID_W-1:0]  id_reg, id_next;
    logic [ID_W-1:0]  ptr_reg, ptr_next;
    logic [ID_W-1:0]  sel_idx;
    logic             sel_found;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= sw_i;
            sync2_reg <= sync1_reg;
        end
    end

    assign tick = (pre_reg == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n)
            pre_reg <= '0;
        else if (tick)
            pre_reg <= '0;
        else
            pre_reg <= pre_reg + PRE_W'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_sw
            logic [CNT_W-1:0] cnt_reg;
            logic             state_reg;
            logic             pend_reg;
            logic             rise_reg;
            logic             accept;

            assign accept = tick && (sync2_reg[gi] != state_reg) &&
                            (cnt_reg == CNT_W'(STABLE_CNT - 1));

            always_ff @(posedge clk_50 or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg   <= '0;
                    state_reg <= 1'b0;
                    pend_reg  <= 1'b0;
                    rise_reg  <= 1'b0;
                end else begin
                    if (tick) begin
                        if (sync2_reg[gi] == state_reg) begin
                            cnt_reg <= '0;
                        end else if (accept) begin
                            cnt_reg   <= '0;
                            state_reg <= sync2_reg[gi];
                            rise_reg  <= sync2_reg[gi];
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    // A fresh acceptance beats a capture in the same cycle.
                    if (accept)
                        pend_reg <= 1'b1;
                    else if (capture_vec[gi])
                        pend_reg <= 1'b0;
                end
            end

            assign sw_state_o[gi]  = state_reg;
            assign pend_vec[gi]    = pend_reg;
            assign rise_vec[gi]    = rise_reg;
            assign ovf_set_vec[gi] = accept && pend_reg && !capture_vec[gi];
        end
    endgenerate

    // First pending switch at or after the pointer, wrapping back to switch 0.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int j = 0; j < N_SW; j++) begin
            if (!sel_found && pend_vec[j] && (ID_W'(j) >= ptr_reg)) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(j);
            end
        end
        for (int j = 0; j < N_SW; j++) begin
            if (!sel_found && pend_vec[j]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(j);
            end
        end
    end

    always_comb begin
        fsm_next      = fsm_reg;
        valid_next    = valid_reg;
        id_next       = id_reg;
        rise_out_next = rise_out_reg;
        ptr_next      = ptr_reg;
        capture_vec   = '0;
        case (fsm_reg)
            S_IDLE: begin
                if (sel_found) begin
                    fsm_next             = S_PRESENT;
                    valid_next           = 1'b1;
                    id_next              = sel_idx;
                    rise_out_next        = rise_vec[sel_idx];
                    capture_vec[sel_idx] = 1'b1;
                    ptr_next = (sel_idx == ID_W'(N_SW - 1)) ? '0 : sel_idx + ID_W'(1);
                end
            end
            S_PRESENT: begin
                if (evt.evt_ready_i) begin
                    fsm_next   = S_IDLE;
                    valid_next = 1'b0;
                end
            end
            default: fsm_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg      <= S_IDLE;
            valid_reg    <= 1'b0;
            id_reg       <= '0;
            rise_out_reg <= 1'b0;
            ptr_reg      <= '0;
        end else begin
            fsm_reg      <= fsm_next;
            valid_reg    <= valid_next;
            id_reg       <= id_next;
            rise_out_reg <= rise_out_next;
            ptr_reg      <= ptr_next;
        end
    end

    // Setting the overflow flag takes priority over a same-cycle clear.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n)
            ovf_reg <= 1'b0;
        else if (|ovf_set_vec)
            ovf_reg <= 1'b1;
        else if (ovf_clr_i)
            ovf_reg <= 1'b0;
    end

    assign ovf_o           = ovf_reg;
    assign evt.evt_valid_o = valid_reg;
    assign evt.evt_id_o    = id_reg;
    assign evt.evt_rise_o  = rise_out_reg;

endmodule

// File: tb/tb_sw_event_scheduler.sv
// Directed bench for sw_event_scheduler with a short tick (TICK_DIV=4, STABLE_CNT=3)
// so debounce, round-robin ordering, overflow and reset behaviour run quickly.
module tb_sw_event_scheduler;
    localparam int N_SW       = 4;
    localparam int TICK_DIV   = 4;
    localparam int STABLE_CNT = 3;

    logic       clk_50    = 1'b0;
    logic       reset_n   = 1'b0;
    logic [3:0] sw_i      = 4'h0;
    logic [3:0] sw_state_o;
    logic       ovf_o;
    logic       ovf_clr_i = 1'b0;

    int         n_assert  = 0;
    int         n_fail    = 0;
    logic [3:0] cur_sw    = 4'h0;
    logic [1:0] exp_ptr   = 2'd0;
    int         lat;
    logic       saw;

    sw_event_scheduler_if #(.ID_W(2)) evt_if ();

    sw_event_scheduler #(
        .N_SW      (N_SW),
        .TICK_DIV  (TICK_DIV),
        .STABLE_CNT(STABLE_CNT)
    ) dut (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .sw_i      (sw_i),
        .sw_state_o(sw_state_o),
        .ovf_o     (ovf_o),
        .ovf_clr_i (ovf_clr_i),
        .evt       (evt_if)
    );

    always #5 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({sw_state_o, evt_if.evt_valid_o, evt_if.evt_id_o, evt_if.evt_rise_o, ovf_o});
    endfunction

    task automatic wait_valid(input string tag);
        int w;
        w = 0;
        while (evt_if.evt_valid_o !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        chk({tag, "_valid"}, 32'(evt_if.evt_valid_o), 32'd1);
    endtask

    // Wait for an event, check it, hold it for 'stall' cycles, then hand-shake it.
    task automatic get_evt(input logic [1:0] eid, input logic erise, input int stall,
                           input string tag);
        wait_valid(tag);
        chk({tag, "_id"}, 32'(evt_if.evt_id_o), 32'(eid));
        chk({tag, "_rise"}, 32'(evt_if.evt_rise_o), 32'(erise));
        for (int s = 0; s < stall; s++) begin
            step();
            chk({tag, "_stall"}, 32'({evt_if.evt_valid_o, evt_if.evt_id_o, evt_if.evt_rise_o}),
                32'({1'b1, eid, erise}));
        end
        evt_if.evt_ready_i = 1'b1;
        step();
        evt_if.evt_ready_i = 1'b0;
        chk({tag, "_drop"}, 32'(evt_if.evt_valid_o), 32'd0);
    endtask

    // Change several switches at once; all accept on the same tick, so the
    // delivery order is a round-robin scan starting at the tracked pointer.
    task automatic deliver(input logic [3:0] newv, input int max_stall, input string tag);
        logic [3:0] mask;
        logic [1:0] id;
        int         st;
        mask   = cur_sw ^ newv;
        cur_sw = newv;
        sw_i   = newv;
        while (mask != 4'h0) begin
            id = exp_ptr;
            while (!mask[id]) id = id + 2'd1;
            st = (max_stall == 0) ? 0 : int'($urandom_range(max_stall, 0));
            get_evt(id, newv[id], st, tag);
            mask[id] = 1'b0;
            exp_ptr  = id + 2'd1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sw_i    = 4'h0;
        cur_sw  = 4'h0;
        exp_ptr = 2'd0;
        #30;
        reset_n = 1'b1;
        step();
    endtask

    task automatic quiet(input int cycles, input string tag);
        saw = 1'b0;
        repeat (cycles) begin
            step();
            if (evt_if.evt_valid_o !== 1'b0) saw = 1'b1;
        end
        chk(tag, 32'(saw), 32'd0);
    endtask

    initial begin
        evt_if.evt_ready_i = 1'b0;

        // Reset and idle
        #150;
        chk("reset_outputs", all_outs(), 32'd0);
        #150;
        reset_n = 1'b1;
        for (int c = 0; c < 200; c++) begin
            evt_if.evt_ready_i = (c == 50);
            step();
            chk("idle_outputs", all_outs(), 32'd0);
        end
        evt_if.evt_ready_i = 1'b0;

        // Bounce: period-3 pattern 1,1,0 never gives three differing samples in a row
        for (int c = 0; c < 40; c++) begin
            sw_i[0] = (c % 3 != 2);
            step();
            chk("bounce_quiet", 32'({sw_state_o, evt_if.evt_valid_o}), 32'd0);
        end
        sw_i[0] = 1'b0;
        repeat (6) begin
            step();
            chk("bounce_tail", 32'({sw_state_o, evt_if.evt_valid_o}), 32'd0);
        end
        sw_i[0] = 1'b1;
        lat = 0;
        while (sw_state_o[0] !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("settle_latency_in_8_to_14", 32'(lat >= 8 && lat <= 14), 32'd1);
        chk("valid_not_same_edge", 32'(evt_if.evt_valid_o), 32'd0);
        step();
        chk("valid_next_cycle", 32'(evt_if.evt_valid_o), 32'd1);
        get_evt(2'd0, 1'b1, 0, "bounce_evt");
        quiet(30, "bounce_single");

        // Round robin from a fresh pointer
        do_reset();
        sw_i = 4'hF;
        get_evt(2'd0, 1'b1, 0, "rr_up0");
        get_evt(2'd1, 1'b1, 0, "rr_up1");
        get_evt(2'd2, 1'b1, 0, "rr_up2");
        get_evt(2'd3, 1'b1, 0, "rr_up3");
        sw_i = 4'h0;
        get_evt(2'd0, 1'b0, 0, "rr_dn0");
        get_evt(2'd1, 1'b0, 0, "rr_dn1");
        get_evt(2'd2, 1'b0, 0, "rr_dn2");
        get_evt(2'd3, 1'b0, 0, "rr_dn3");
        quiet(20, "rr_no_extra");

        // Backpressure and overflow on switch 2 while switch 0's event is stalled
        sw_i = 4'b0001;
        wait_valid("ovf_hold");
        chk("ovf_hold_id", 32'(evt_if.evt_id_o), 32'd0);
        sw_i[2] = 1'b1;
        lat = 0;
        while (sw_state_o[2] !== 1'b1 && lat < 40) begin step(); lat++; end
        chk("ovf_press_state", 32'(sw_state_o), 32'b0101);
        chk("ovf_not_yet", 32'(ovf_o), 32'd0);
        sw_i[2] = 1'b0;
        lat = 0;
        while (sw_state_o[2] !== 1'b0 && lat < 40) begin step(); lat++; end
        chk("ovf_release_state", 32'(sw_state_o), 32'b0001);
        chk("ovf_set", 32'(ovf_o), 32'd1);
        chk("ovf_hold_stable", 32'({evt_if.evt_valid_o, evt_if.evt_id_o, evt_if.evt_rise_o}),
            32'b1001);
        get_evt(2'd0, 1'b1, 0, "ovf_evt0");
        get_evt(2'd2, 1'b0, 0, "ovf_evt2");
        quiet(30, "ovf_single");
        chk("ovf_sticky", 32'(ovf_o), 32'd1);
        ovf_clr_i = 1'b1;
        step();
        ovf_clr_i = 1'b0;
        chk("ovf_cleared", 32'(ovf_o), 32'd0);
        cur_sw  = 4'b0001;
        exp_ptr = 2'd3;

        // Valid stability under random ready stalls, 52 events
        for (int r = 0; r < 13; r++) deliver(~cur_sw, 3, "stab");
        quiet(20, "stab_no_extra");
        chk("stab_no_ovf", 32'(ovf_o), 32'd0);

        // Reset while an event is presented
        deliver(4'h0, 0, "pre_rst");
        sw_i = 4'b0010;
        wait_valid("rst_pres");
        chk("rst_pres_id", 32'(evt_if.evt_id_o), 32'd1);
        @(posedge clk_50);
        #2;
        reset_n = 1'b0;
        sw_i    = 4'h0;
        #1;
        chk("rst_immediate", all_outs(), 32'd0);
        #20;
        reset_n = 1'b1;
        cur_sw  = 4'h0;
        exp_ptr = 2'd0;
        quiet(40, "rst_no_replay");
        sw_i = 4'b0010;
        get_evt(2'd1, 1'b1, 0, "rst_fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sw_event_scheduler.md
# sw_event_scheduler

Debounces N board switches with one shared sample-tick prescaler and per-switch stability counters. It turns every accepted level change into a press/release event and schedules pending events round-robin onto a single valid/ready event port. It sits between the raw `sw_i` pins and the board logic (LED/display controllers), replacing one free-running debouncer per switch.

## Interface
- `N_SW`, 4: number of switch inputs, 1..16.
- `TICK_DIV`, 50000: clk_50 cycles per sample tick (1 ms at 50 MHz), ≥2.
- `STABLE_CNT`, 8: consecutive differing ticks required to accept a change, ≥1.
- `clk_50` input 1: system clock, 50 MHz; the only clock.
- `reset_n` input 1: asynchronous active-low reset.
- `sw_i` input N_SW: raw, asynchronous, bouncing switch levels.
- `sw_state_o` output N_SW: debounced levels.
- `evt_valid_o` output 1: an event is presented.
- `evt_ready_i` input 1: the consumer accepts the event.
- `evt_id_o` output $clog2(N_SW) (min 1): index of the switch that changed.
- `evt_rise_o` output 1: 1 = 0→1 change, 0 = 1→0 change.
- `ovf_o` output 1: sticky flag; an event was overwritten before it was delivered.
- `ovf_clr_i` input 1: synchronous clear of `ovf_o`.

## Operation
- Reset values: `sw_state_o` = 0, `evt_valid_o` = 0, `evt_id_o` = 0, `evt_rise_o` = 0, `ovf_o` = 0. All counters, pending bits and the round-robin pointer are also 0 (pointer → switch 0).
- Synchronizer: each `sw_i` bit passes through 2 flops into `sync[i]`. The synchronizer flops reset to 0.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. `tick` is high for 1 cycle when count == TICK_DIV-1.
- Per switch, evaluated on `tick` only:
  - If sync == state: cnt ← 0.
  - Else if cnt == STABLE_CNT-1: state ← sync, cnt ← 0, pend ← 1, rise ← sync.
  - Else: cnt ← cnt+1.
  - A single equal tick restarts the count.
- Overwrite: if a switch accepts a change while its pend is already 1, rise takes the new value, pend stays 1 and `ovf_o` ← 1.
- Event FSM, 2 states:
  - IDLE: if any pend is set, select the first set pend at or after the pointer (wrapping at N_SW-1 → 0). Register `evt_id_o`/`evt_rise_o`, set `evt_valid_o`, clear that pend, set pointer ← id+1 (wrapping) and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: hold `evt_valid_o`, `evt_id_o` and `evt_rise_o` stable. When `evt_ready_i`=1 at a clock edge, drop valid and return to IDLE.
- Simultaneous capture and new acceptance on the same switch: the acceptance wins. pend stays 1, no overflow is flagged, and the presented event carries the pre-capture rise.
- Simultaneous `ovf_clr_i` and a new overflow: the set wins.
- `evt_ready_i` while valid = 0 is ignored.
- Reset asserted mid-presentation: outputs go to their reset values immediately; pending events are discarded.

## Timing
- Raw edge → sync: 2 cycles.
- A change is accepted on the STABLE_CNT-th consecutive differing tick. With ideal input this is between (STABLE_CNT-1)·TICK_DIV+1 and STABLE_CNT·TICK_DIV cycles after sync changes.
- `sw_state_o` and pend update at the same edge. `evt_valid_o` rises 1 cycle later if the FSM is in IDLE.
- Handshake: an event transfers at the edge where valid & ready are both 1. The next valid comes no earlier than 2 cycles later (1 IDLE cycle), so throughput is at most 1 event per 2 cycles.
- Valid never drops without a handshake, and id/rise never change while valid = 1.

## Test plan
Run all scenarios with TICK_DIV=4, STABLE_CNT=3, N_SW=4.
- Reset/idle: hold reset_n=0 for 300 ns with sw_i=4'b0000, then release → all outputs stay 0 for 200 cycles; a bench pulse of `evt_ready_i` has no effect.
- Bounce rejection: toggle sw_i[0] randomly every 1–2 cycles for 40 cycles, then settle at 1 → exactly one event (id=0, rise=1); `sw_state_o[0]` goes to 1 no sooner than 8 cycles after settling; no event during the bounce.
- Round robin: hold `evt_ready_i`=0 and raise sw_i[3:0]=4'b1111 together, then set ready=1 → events delivered in order id 0,1,2,3, each with rise=1; after a 1→0 change on all switches the next order starts at 0 again (pointer wrapped).
- Backpressure/overflow: ready=0, press then release switch 2, each change stable long enough to be accepted → `ovf_o`=1 and a single delivered event has id=2, rise=0; pulse `ovf_clr_i` → `ovf_o`=0.
- Valid stability: random ready stalls across 50 events from all switches → id/rise never change while valid=1, there are no lost or duplicated events (with no overflow), and valid never drops without a handshake.
- Reset mid-operation: assert reset_n=0 while valid=1 → valid=0 and `sw_state_o`=0 in the same cycle; after release the event is not re-presented until a fresh change is accepted.
